// File: rtl/logic_pkg.sv
// Shared op encoding for the bitwise/accumulator unit and the ALU op decoder.
package logic_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND      = 3'b000;
    localparam op_t OP_OR       = 3'b001;
    localparam op_t OP_XOR      = 3'b010;
    localparam op_t OP_NAND     = 3'b011;
    localparam op_t OP_NOR      = 3'b100;
    localparam op_t OP_XNOR     = 3'b101;
    localparam op_t OP_ACC_XOR  = 3'b110;
    localparam op_t OP_ACC_LOAD = 3'b111;

endpackage

// File: rtl/bitwise_core.sv
// Stateless datapath: selected bitwise op plus next accumulator value.
module bitwise_core
    import logic_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] next_result,
    output logic [WIDTH-1:0] next_acc
);

    // Operation decode; accumulator passes through except for the two ACC ops.
    always_comb begin
        next_result = {WIDTH{1'b0}};
        next_acc    = acc;
        case (op)
            OP_AND:      next_result = a & b;
            OP_OR:       next_result = a | b;
            OP_XOR:      next_result = a ^ b;
            OP_NAND:     next_result = ~(a & b);
            OP_NOR:      next_result = ~(a | b);
            OP_XNOR:     next_result = ~(a ^ b);
            OP_ACC_XOR: begin
                next_acc    = acc ^ a ^ b;
                next_result = acc ^ a ^ b;
            end
            OP_ACC_LOAD: begin
                next_acc    = a;
                next_result = a;
            end
            default: begin
                next_result = {WIDTH{1'b0}};
                next_acc    = acc;
            end
        endcase
    end

endmodule

// File: rtl/logic_unit_acc.sv
// Bitwise unit with XOR accumulator, single output register and valid/ready handshake.
module logic_unit_acc
    import logic_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_parity,
    output logic [WIDTH-1:0] acc
);

    function automatic logic calc_parity(input logic [WIDTH-1:0] v);
        calc_parity = ^v;
    endfunction

    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             flag_zero_r;
    logic             flag_parity_r;
    logic [WIDTH-1:0] acc_r;

    logic             accept_s;
    logic [WIDTH-1:0] next_result_s;
    logic [WIDTH-1:0] next_acc_s;
    logic             next_zero_s;
    logic             next_parity_s;

    // Ready whenever the output register is empty or being drained this cycle.
    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    bitwise_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op          (op_t'(op)),
        .a           (a),
        .b           (b),
        .acc         (acc_r),
        .next_result (next_result_s),
        .next_acc    (next_acc_s)
    );

    // Flags derive from the value about to be registered, never the held one.
    always_comb begin
        next_zero_s   = (next_result_s == {WIDTH{1'b0}});
        next_parity_s = calc_parity(next_result_s);
    end

    // Output register and accumulator; reset overrides any same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            result_r      <= {WIDTH{1'b0}};
            flag_zero_r   <= 1'b0;
            flag_parity_r <= 1'b0;
            acc_r         <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            out_valid_r   <= 1'b1;
            result_r      <= next_result_s;
            flag_zero_r   <= next_zero_s;
            flag_parity_r <= next_parity_s;
            acc_r         <= next_acc_s;
        end else if (out_ready) begin
            out_valid_r   <= 1'b0;
        end
    end

    assign out_valid   = out_valid_r;
    assign result      = result_r;
    assign flag_zero   = flag_zero_r;
    assign flag_parity = flag_parity_r;
    assign acc         = acc_r;

endmodule

// File: tb/tb_logic_unit_acc.sv
// Directed plus randomized bench for logic_unit_acc (WIDTH=4) against a behavioural model.
module tb_logic_unit_acc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] op = 3'd0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] result;
    logic       flag_zero;
    logic       flag_parity;
    logic [3:0] acc;

    int n_checks = 0;
    int n_pass   = 0;

    logic_unit_acc #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flag_zero   (flag_zero),
        .flag_parity (flag_parity),
        .acc         (acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // One bus cycle: drive at negedge, return shortly after the following rising edge.
    task automatic cycle(input logic r, input logic iv, input logic [2:0] o,
                         input logic [3:0] ta, input logic [3:0] tb_v, input logic ordy);
        @(negedge clk);
        rst = r; in_valid = iv; op = o; a = ta; b = tb_v; out_ready = ordy;
        @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural model ----------------
    int   m_valid, m_res, m_acc, m_zero, m_par, m_known;
    int   s_r, s_iv, s_op, s_a, s_b, s_ordy, s_ready;

    function automatic int ones(input int v);
        int c = 0;
        for (int i = 0; i < 4; i++) if (((v >> i) & 1) == 1) c++;
        return c;
    endfunction

    initial begin
        m_valid = 0; m_res = 0; m_acc = 0; m_zero = 0; m_par = 0; m_known = 0;
        forever begin
            @(posedge clk);
            s_r = int'(rst); s_iv = int'(in_valid); s_op = int'(op);
            s_a = int'(a); s_b = int'(b); s_ordy = int'(out_ready);
            s_ready = (m_valid == 0 || s_ordy == 1) ? 1 : 0;
            if (s_r == 1) begin
                m_valid = 0; m_res = 0; m_acc = 0; m_zero = 0; m_par = 0; m_known = 1;
            end else if (m_known == 1) begin
                if (s_iv == 1 && s_ready == 1) begin
                    case (s_op)
                        0: m_res = s_a & s_b;
                        1: m_res = s_a | s_b;
                        2: m_res = s_a ^ s_b;
                        3: m_res = 15 - (s_a & s_b);
                        4: m_res = 15 - (s_a | s_b);
                        5: m_res = 15 - (s_a ^ s_b);
                        6: begin m_acc = m_acc ^ s_a ^ s_b; m_res = m_acc; end
                        default: begin m_acc = s_a; m_res = s_a; end
                    endcase
                    m_zero  = (m_res == 0) ? 1 : 0;
                    m_par   = ones(m_res) % 2;
                    m_valid = 1;
                end else if (s_ordy == 1) begin
                    m_valid = 0;
                end
            end
            #2;
            if (m_known == 1) begin
                chk("model out_valid", 32'(out_valid), 32'(m_valid));
                chk("model in_ready", 32'(in_ready), (m_valid == 0 || s_ordy == 1) ? 32'd1 : 32'd0);
                chk("model acc", 32'(acc), 32'(m_acc));
                chk("model result", 32'(result), 32'(m_res));
                chk("model flag_zero", 32'(flag_zero), 32'(m_zero));
                chk("model flag_parity", 32'(flag_parity), 32'(m_par));
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    logic [3:0] exp_ops [6];

    initial begin
        exp_ops[0] = 4'b1000; exp_ops[1] = 4'b1110; exp_ops[2] = 4'b0110;
        exp_ops[3] = 4'b0111; exp_ops[4] = 4'b0001; exp_ops[5] = 4'b1001;

        // 1. reset and op coverage
        cycle(1'b1, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
        cycle(1'b1, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset acc", 32'(acc), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 3'(i), 4'b1100, 4'b1010, 1'b1);
            chk($sformatf("op%0d result", i), 32'(result), 32'(exp_ops[i]));
            chk($sformatf("op%0d out_valid", i), 32'(out_valid), 32'd1);
        end

        // 2. flags
        cycle(1'b0, 1'b1, 3'b010, 4'b0101, 4'b0101, 1'b1);
        chk("xor zero result", 32'(result), 32'd0);
        chk("xor zero flag_zero", 32'(flag_zero), 32'd1);
        chk("xor zero flag_parity", 32'(flag_parity), 32'd0);
        cycle(1'b0, 1'b1, 3'b001, 4'b0111, 4'b0000, 1'b1);
        chk("or flag_zero", 32'(flag_zero), 32'd0);
        chk("or flag_parity", 32'(flag_parity), 32'd1);

        // 3. accumulator chain
        cycle(1'b0, 1'b1, 3'b111, 4'hA, 4'h5, 1'b1);
        chk("load result", 32'(result), 32'hA);
        chk("load acc", 32'(acc), 32'hA);
        cycle(1'b0, 1'b1, 3'b110, 4'h3, 4'h0, 1'b1);
        chk("accxor1 result", 32'(result), 32'h9);
        cycle(1'b0, 1'b1, 3'b000, 4'hF, 4'h1, 1'b1);
        chk("and keeps acc", 32'(acc), 32'h9);
        cycle(1'b0, 1'b1, 3'b110, 4'h9, 4'h0, 1'b1);
        chk("accxor2 result", 32'(result), 32'h0);
        chk("accxor2 flag_zero", 32'(flag_zero), 32'd1);

        // 4. backpressure
        cycle(1'b0, 1'b1, 3'b010, 4'h5, 4'h3, 1'b1);
        chk("bp xor result", 32'(result), 32'h6);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 3'b110, 4'hF, 4'h0, 1'b0);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp result held", 32'(result), 32'h6);
            chk("bp acc held", 32'(acc), 32'h0);
        end
        cycle(1'b0, 1'b1, 3'b110, 4'hF, 4'h0, 1'b1);
        chk("bp release result", 32'(result), 32'hF);
        chk("bp release acc", 32'(acc), 32'hF);
        chk("bp release valid", 32'(out_valid), 32'd1);

        // 5. reset mid-operation
        cycle(1'b0, 1'b1, 3'b111, 4'h5, 4'h0, 1'b1);
        cycle(1'b0, 1'b0, 3'b000, 4'h0, 4'h0, 1'b0);
        chk("pre-rst acc", 32'(acc), 32'h5);
        chk("pre-rst held", 32'(out_valid), 32'd1);
        cycle(1'b1, 1'b1, 3'b110, 4'h3, 4'h0, 1'b0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst result", 32'(result), 32'd0);
        chk("midrst acc", 32'(acc), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);

        // 6. idle and drain
        cycle(1'b0, 1'b1, 3'b001, 4'h1, 4'h2, 1'b1);
        chk("drain pre result", 32'(result), 32'h3);
        cycle(1'b0, 1'b0, 3'b000, 4'h0, 4'h0, 1'b1);
        chk("drain out_valid", 32'(out_valid), 32'd0);
        chk("drain acc", 32'(acc), 32'd0);

        // randomized traffic, checked by the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
